// File: rtl/clk_div_gen_pkg.sv
// clk_div_gen_pkg: shared types and constants for the multi-channel clock divider
package clk_div_gen_pkg;
    typedef enum logic [1:0] {CH_IDLE, CH_PHASE, CH_RUN} ch_state_t;
    localparam int MIN_PERIOD = 2;
endpackage

// File: rtl/clk_div_channel.sv
// clk_div_channel: one divided-clock channel with start delay and wrap-aligned reconfiguration
module clk_div_channel
    import clk_div_gen_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sync_i,
    input  logic                 wr_i,
    input  logic                 en_i,
    input  logic [CNT_WIDTH-1:0] per_i,
    input  logic [CNT_WIDTH-1:0] high_i,
    input  logic [CNT_WIDTH-1:0] ph_i,
    output logic                 div_clk_o,
    output logic                 div_rise_o,
    output logic                 active_o,
    output logic                 pend_o
);
    typedef logic [CNT_WIDTH-1:0] cnt_t;
    ch_state_t state_q, state_d;
    cnt_t cnt_q, cnt_d, per_q, per_d, high_q, high_d, ph_q, ph_d;
    cnt_t pper_q, pper_d, phigh_q, phigh_d, pph_q, pph_d;
    cnt_t sel_per, sel_high, sel_ph, go_ph;
    logic pend_q, pend_d, pen_q, pen_d, clk_q, clk_d, rise_q, rise_d;
    logic wrap, restart, load, go_en;

    // A new or pending config lands at any boundary; while running, only wrap or sync are boundaries.
    assign wrap     = state_q == CH_RUN && cnt_q == per_q - cnt_t'(1);
    assign restart  = sync_i && state_q != CH_IDLE;
    assign load     = (wr_i && (state_q != CH_RUN || wrap || restart)) || (pend_q && (wrap || restart));
    assign sel_per  = wr_i ? per_i : pper_q;
    assign sel_high = wr_i ? high_i : phigh_q;
    assign sel_ph   = wr_i ? ph_i : pph_q;
    assign go_en    = !load || (wr_i ? en_i : pen_q);
    assign go_ph    = load ? sel_ph : ph_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CH_IDLE;
            cnt_q   <= '0;
            per_q   <= '0;
            high_q  <= '0;
            ph_q    <= '0;
            pend_q  <= 1'b0;
            pen_q   <= 1'b0;
            pper_q  <= '0;
            phigh_q <= '0;
            pph_q   <= '0;
            clk_q   <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            high_q  <= high_d;
            ph_q    <= ph_d;
            pend_q  <= pend_d;
            pen_q   <= pen_d;
            pper_q  <= pper_d;
            phigh_q <= phigh_d;
            pph_q   <= pph_d;
            clk_q   <= clk_d;
            rise_q  <= rise_d;
        end
    end

    always_comb begin
        per_d   = load ? sel_per : per_q;
        high_d  = load ? sel_high : high_q;
        ph_d    = go_ph;
        pend_d  = !load && (pend_q || wr_i);
        pen_d   = wr_i ? en_i : pen_q;
        pper_d  = wr_i ? per_i : pper_q;
        phigh_d = wr_i ? high_i : phigh_q;
        pph_d   = wr_i ? ph_i : pph_q;
        if (load || restart) begin
            state_d = !go_en ? CH_IDLE : (go_ph == '0 ? CH_RUN : CH_PHASE);
            cnt_d   = go_ph;
        end else begin
            state_d = (state_q == CH_PHASE && cnt_q == cnt_t'(1)) ? CH_RUN : state_q;
            cnt_d   = state_q == CH_RUN ? (wrap ? '0 : cnt_q + cnt_t'(1)) :
                      state_q == CH_PHASE ? cnt_q - cnt_t'(1) : cnt_q;
        end
    end

    always_comb begin
        clk_d  = state_d == CH_RUN && cnt_d < high_d;
        rise_d = state_d == CH_RUN && cnt_d == '0;
    end

    assign div_clk_o  = clk_q;
    assign div_rise_o = rise_q;
    assign active_o   = state_q == CH_RUN;
    assign pend_o     = pend_q;
endmodule

// File: rtl/clk_div_gen_mc.sv
// clk_div_gen_mc: multi-channel programmable clock/strobe generator with glitch-free reconfiguration
module clk_div_gen_mc
    import clk_div_gen_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 16,
    localparam int CH_W     = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic                 cfg_enable,
    input  logic [CNT_WIDTH-1:0] cfg_period,
    input  logic [CNT_WIDTH-1:0] cfg_high,
    input  logic [CNT_WIDTH-1:0] cfg_phase,
    input  logic                 sync,
    output logic                 cfg_err,
    output logic [NUM_CH-1:0]    div_clk,
    output logic [NUM_CH-1:0]    div_rise,
    output logic [NUM_CH-1:0]    ch_active
);
    logic ok, acc, err_q, err_d;
    logic [NUM_CH-1:0] wr, pend;
    logic [2**CH_W-1:0] pend_ext;

    assign ok = !cfg_enable || (cfg_period >= CNT_WIDTH'(MIN_PERIOD) && cfg_high != '0 &&
                                cfg_high < cfg_period && cfg_phase < cfg_period);

    // Unused channel codes read as never-pending so writes to them are simply consumed.
    always_comb begin
        pend_ext = '0;
        pend_ext[NUM_CH-1:0] = pend;
    end

    assign cfg_ready = !pend_ext[cfg_ch];
    assign acc       = cfg_valid && cfg_ready;
    assign err_d     = acc && !ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign cfg_err = err_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr[i] = acc && ok && cfg_ch == CH_W'(i);
        clk_div_channel #(.CNT_WIDTH(CNT_WIDTH)) u_ch (
            .clk        (clk),
            .reset      (reset),
            .sync_i     (sync),
            .wr_i       (wr[i]),
            .en_i       (cfg_enable),
            .per_i      (cfg_period),
            .high_i     (cfg_high),
            .ph_i       (cfg_phase),
            .div_clk_o  (div_clk[i]),
            .div_rise_o (div_rise[i]),
            .active_o   (ch_active[i]),
            .pend_o     (pend[i])
        );
    end
endmodule

// File: tb/tb_clk_div_gen_mc.sv
// tb_clk_div_gen_mc: directed checks of channel waveforms, reconfiguration, errors, sync and reset
module tb_clk_div_gen_mc;
    localparam int NUM_CH = 4;
    localparam int CW = 16;

    logic clk = 1'b0, reset = 1'b1, cfg_valid = 1'b0, cfg_enable = 1'b0, sync = 1'b0;
    logic [1:0] cfg_ch = '0;
    logic [CW-1:0] cfg_period = '0, cfg_high = '0, cfg_phase = '0;
    logic cfg_ready, cfg_err;
    logic [NUM_CH-1:0] div_clk, div_rise, ch_active;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    clk_div_gen_mc #(.NUM_CH(NUM_CH), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_enable (cfg_enable),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .cfg_phase  (cfg_phase),
        .sync       (sync),
        .cfg_err    (cfg_err),
        .div_clk    (div_clk),
        .div_rise   (div_rise),
        .ch_active  (ch_active)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [1:0] ch, input logic en, input int p, input int h, input int ph);
        cfg_valid  = 1'b1;
        cfg_ch     = ch;
        cfg_enable = en;
        cfg_period = CW'(p);
        cfg_high   = CW'(h);
        cfg_phase  = CW'(ph);
        #1;
        check("cfg_ready_before_accept", 32'(cfg_ready), 32'd1);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic watch(input string tag, input int ch, input int n,
                         input logic [31:0] cp, input logic [31:0] rp, input logic [31:0] ap);
        for (int j = 0; j < n; j++) begin
            check({tag, "_clk"}, 32'(div_clk[ch]), 32'(cp[n-1-j]));
            check({tag, "_rise"}, 32'(div_rise[ch]), 32'(rp[n-1-j]));
            check({tag, "_active"}, 32'(ch_active[ch]), 32'(ap[n-1-j]));
            tick();
        end
    endtask

    initial begin
        #12;
        check("rst_div_clk", 32'(div_clk), 32'd0);
        check("rst_div_rise", 32'(div_rise), 32'd0);
        check("rst_active", 32'(ch_active), 32'd0);
        check("rst_err", 32'(cfg_err), 32'd0);
        check("rst_ready", 32'(cfg_ready), 32'd1);
        reset = 1'b0;

        cfg(2'd0, 1'b1, 4, 2, 0);
        watch("t1_ch0", 0, 8, 32'b11001100, 32'b10001000, 32'hFF);

        cfg(2'd1, 1'b1, 5, 1, 3);
        watch("t2_ch1", 1, 10, 32'b0001000010, 32'b0001000010, 32'b0001111111);

        for (int j = 0; j < 10 && !div_rise[0]; j++) tick();
        check("t3_find_rise", 32'(div_rise[0]), 32'd1);
        tick();
        cfg(2'd0, 1'b1, 6, 3, 0);
        check("t3_ready_pending", 32'(cfg_ready), 32'd0);
        watch("t3_old", 0, 2, 32'b00, 32'b00, 32'b11);
        check("t3_ready_applied", 32'(cfg_ready), 32'd1);
        watch("t3_new", 0, 12, 32'b111000111000, 32'b100000100000, 32'hFFF);

        cfg(2'd0, 1'b1, 1, 1, 0);
        check("t4_err_p1", 32'(cfg_err), 32'd1);
        check("t4_clk_p1", 32'(div_clk[0]), 32'd1);
        tick();
        check("t4_err_p1_clear", 32'(cfg_err), 32'd0);
        cfg(2'd0, 1'b1, 4, 4, 0);
        check("t4_err_h4", 32'(cfg_err), 32'd1);
        check("t4_clk_h4", 32'(div_clk[0]), 32'd0);
        tick();
        check("t4_err_h4_clear", 32'(cfg_err), 32'd0);
        check("t4_ready", 32'(cfg_ready), 32'd1);
        watch("t4_keep", 0, 6, 32'b001110, 32'b001000, 32'h3F);

        cfg(2'd0, 1'b1, 4, 2, 0);
        cfg(2'd1, 1'b1, 8, 4, 2);
        sync = 1'b1;
        tick();
        sync = 1'b0;
        check("t5_ch0_rise_s", 32'(div_rise[0]), 32'd1);
        check("t5_ch0_clk_s", 32'(div_clk[0]), 32'd1);
        watch("t5_ch1", 1, 10, 32'b0011110000, 32'b0010000000, 32'b0011111111);
        check("t5_ch0_clk_s10", 32'(div_clk[0]), 32'd0);

        tick();
        tick();
        check("t6_clk_before", 32'(div_clk[0]), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t6_async_clk", 32'(div_clk), 32'd0);
        check("t6_async_rise", 32'(div_rise), 32'd0);
        check("t6_async_active", 32'(ch_active), 32'd0);
        check("t6_async_ready", 32'(cfg_ready), 32'd1);
        tick();
        tick();
        reset = 1'b0;
        sync = 1'b1;
        tick();
        sync = 1'b0;
        for (int j = 0; j < 4; j++) begin
            check("t6_idle_clk", 32'(div_clk), 32'd0);
            check("t6_idle_active", 32'(ch_active), 32'd0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
